// File: rtl/half_subtractor_pkg.sv
// Shared constants and helpers for the half_subtractor block.
// Holds the default operand/counter widths and the counter saturation value.
package half_subtractor_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 16;

  // All-ones value of a cnt_w-bit counter, computed in 64 bits so cnt_w=32 is safe.
  function automatic logic [63:0] cnt_sat_value(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/hs_bit.sv
// One stage of the ripple-borrow subtractor chain.
// With bin tied low this is a plain half subtractor.
module hs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/half_subtractor.sv
// Registered WIDTH-bit subtractor: diff = a - b (mod 2^WIDTH), borrow = (a < b).
// One clock of latency, no back-pressure; out_valid follows in_valid by one clock.
// Optional feature macro: HALF_SUBTRACTOR_STATS_EN adds cnt_clr/borrow_count,
// a saturating count of accepted operations that produced a borrow.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid
`ifdef HALF_SUBTRACTOR_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] borrow_count
`endif
);

  // Reject widths outside the supported range at elaboration.
  if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
    $error("half_subtractor: WIDTH and CNT_W must be in 1..32");
  end

  logic [WIDTH-1:0] diff_next;
  logic [WIDTH:0]   bchain;
  logic             borrow_next;

  // Bit 0 has no incoming borrow; the last stage's borrow-out is the result borrow.
  assign bchain[0]   = 1'b0;
  assign borrow_next = bchain[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    hs_bit u_bit (
      .x    (a[i]),
      .y    (b[i]),
      .bin  (bchain[i]),
      .d    (diff_next[i]),
      .bout (bchain[i+1])
    );
  end

  // Result registers: load on accepted operands, otherwise hold.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (in_valid) begin
      diff   <= diff_next;
      borrow <= borrow_next;
    end
  end

  // Output strobe: in_valid delayed one clock; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

`ifdef HALF_SUBTRACTOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_value(CNT_W));

  // Saturating borrow-event counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_count <= '0;
    end else if (cnt_clr) begin
      borrow_count <= '0;
    end else if (in_valid && borrow_next && (borrow_count != CNT_MAX)) begin
      borrow_count <= borrow_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Scoreboard bench for half_subtractor: a WIDTH=1 and a WIDTH=8 (CNT_W=4) instance.
// Stimulus pushes expected results; negedge monitors pop on out_valid and compare.
// Counter checks are compiled when HALF_SUBTRACTOR_STATS_EN is defined.
module tb_half_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a1, b1, v1, d1, bo1, ov1;
  logic [7:0] a8, b8, d8;
  logic       v8, bo8, ov8;
`ifdef HALF_SUBTRACTOR_STATS_EN
  logic        clr1, clr8;
  logic [15:0] cnt1;
  logic [3:0]  cnt8;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  half_subtractor #(.WIDTH(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a1),
    .b            (b1),
    .in_valid     (v1),
    .diff         (d1),
    .borrow       (bo1),
    .out_valid    (ov1)
`ifdef HALF_SUBTRACTOR_STATS_EN
    ,
    .cnt_clr      (clr1),
    .borrow_count (cnt1)
`endif
  );

  half_subtractor #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a8),
    .b            (b8),
    .in_valid     (v8),
    .diff         (d8),
    .borrow       (bo8),
    .out_valid    (ov8)
`ifdef HALF_SUBTRACTOR_STATS_EN
    ,
    .cnt_clr      (clr8),
    .borrow_count (cnt8)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (rst_n && ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("w1 spurious out_valid", {31'd0, ov1}, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("w1 diff", {31'd0, d1}, {31'd0, e.d[0]});
        check("w1 borrow", {31'd0, bo1}, {31'd0, e.b});
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n && ov8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8 spurious out_valid", {31'd0, ov8}, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8 diff", {24'd0, d8}, {24'd0, e.d});
        check("w8 borrow", {31'd0, bo8}, {31'd0, e.b});
      end
    end
  end

  task automatic issue1(input logic a, input logic b, input logic ed, input logic eb);
    @(posedge clk); #1;
    a1 = a; b1 = b; v1 = 1'b1;
    q1.push_back(exp_t'{d: {7'd0, ed}, b: eb});
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb);
    @(posedge clk); #1;
    a8 = a; b8 = b; v8 = 1'b1;
    q8.push_back(exp_t'{d: ed, b: eb});
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    v8 = 1'b0;
`ifdef HALF_SUBTRACTOR_STATS_EN
    clr8 = 1'b0;
`endif
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;
`ifdef HALF_SUBTRACTOR_STATS_EN
    clr1 = 1'b0; clr8 = 1'b0;
`endif

    // Reset state.
    #12;
    check("reset diff", {24'd0, d8}, 32'd0);
    check("reset borrow", {31'd0, bo8}, 32'd0);
    check("reset out_valid", {31'd0, ov8}, 32'd0);
    check("reset w1 out_valid", {31'd0, ov1}, 32'd0);
`ifdef HALF_SUBTRACTOR_STATS_EN
    check("reset count", {28'd0, cnt8}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 truth table, back-to-back.
    issue1(1'b0, 1'b0, 1'b0, 1'b0);
    issue1(1'b0, 1'b1, 1'b1, 1'b1);
    issue1(1'b1, 1'b0, 1'b1, 1'b0);
    issue1(1'b1, 1'b1, 1'b0, 1'b0);
    idle1();
    repeat (3) @(posedge clk);

    // WIDTH=8 directed vectors, back-to-back.
    issue8(8'h00, 8'h01, 8'hFF, 1'b1);
    issue8(8'h80, 8'h7F, 8'h01, 1'b0);
    issue8(8'h5A, 8'h3C, 8'h1E, 1'b0);
    issue8(8'h3C, 8'h5A, 8'hE2, 1'b1);
    issue8(8'hFF, 8'hFF, 8'h00, 1'b0);
    issue8(8'h00, 8'hFF, 8'h01, 1'b1);
    idle8();

    // Outputs hold while in_valid is low, even as operands change.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold diff", {24'd0, d8}, 32'h01);
      check("hold borrow", {31'd0, bo8}, 32'd1);
      check("hold out_valid", {31'd0, ov8}, 32'd0);
      a8 = 8'h10 + 8'(i);
      b8 = 8'hF0 - 8'(i);
    end

`ifdef HALF_SUBTRACTOR_STATS_EN
    // Three borrowing ops so far.
    check("count after vectors", {28'd0, cnt8}, 32'd3);
    for (int i = 0; i < 20; i++) begin
      issue8(8'h10, 8'h20, 8'hF0, 1'b1);
    end
    idle8();
    check("count saturated", {28'd0, cnt8}, 32'd15);
    // Clear wins over a simultaneous borrowing op.
    @(posedge clk); #1;
    a8 = 8'h00; b8 = 8'h01; v8 = 1'b1; clr8 = 1'b1;
    q8.push_back(exp_t'{d: 8'hFF, b: 1'b1});
    idle8();
    check("count clear wins", {28'd0, cnt8}, 32'd0);
    // Non-borrowing op leaves the count; borrowing op increments it.
    issue8(8'h01, 8'h00, 8'h01, 1'b0);
    issue8(8'h01, 8'h02, 8'hFF, 1'b1);
    idle8();
    check("count after clear", {28'd0, cnt8}, 32'd1);
    check("w1 count untouched", {16'd0, cnt1}, 32'd1);
`endif

    // Reset pulled low between edges while an operation is in flight.
    @(posedge clk); #1;
    a8 = 8'h77; b8 = 8'h88; v8 = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    v8 = 1'b0;
    check("async reset diff", {24'd0, d8}, 32'd0);
    check("async reset borrow", {31'd0, bo8}, 32'd0);
    check("async reset out_valid", {31'd0, ov8}, 32'd0);
`ifdef HALF_SUBTRACTOR_STATS_EN
    check("async reset count", {28'd0, cnt8}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("out_valid after release", {31'd0, ov8}, 32'd0);
    check("diff after release", {24'd0, d8}, 32'd0);
    issue8(8'h09, 8'h03, 8'h06, 1'b0);
    idle8();

    // Drain: every pushed expectation must have been consumed.
    repeat (4) @(posedge clk);
    check("w1 queue drained", q1.size(), 32'd0);
    check("w8 queue drained", q8.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
